// File: rtl/serial_fft_coral.sv
// Serial single-bin DFT accumulator: multiplies each incoming multichannel
// sample by an externally supplied twiddle W[k] and accumulates per channel,
// restarting the sums at k=0 and flagging the frame's last sample.
module serial_fft_coral #(
  parameter int unsigned W_WIDTH      = 16,
  parameter int unsigned X_WIDTH      = 16,
  parameter int unsigned S_WIDTH      = 32,
  parameter int unsigned FRAME_LENGTH = 10,
  parameter int unsigned CHANELS      = 2
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  output logic [$clog2(FRAME_LENGTH)-1:0]           counter,
  input  logic signed [W_WIDTH-1:0]                 w_re,
  input  logic signed [W_WIDTH-1:0]                 w_im,
  input  logic                                      valid_i,
  input  logic signed [CHANELS-1:0][X_WIDTH-1:0]    x,
  output logic signed [CHANELS-1:0][S_WIDTH-1:0]    re,
  output logic signed [CHANELS-1:0][S_WIDTH-1:0]    im,
  output logic                                      valid_o,
  output logic                                      finish
);

  localparam int unsigned CW = $clog2(FRAME_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LENGTH - 1);

  // stage 1: registered sample, its index and valid flag
  logic [CHANELS-1:0][X_WIDTH-1:0] s1_x;
  logic [CW-1:0]                   s1_k;
  logic                            s1_valid;

  // stage 2: registered products, index and valid flag
  logic signed [S_WIDTH-1:0] p2_re [CHANELS];
  logic signed [S_WIDTH-1:0] p2_im [CHANELS];
  logic [CW-1:0]             s2_k;
  logic                      s2_valid;

  logic signed [S_WIDTH-1:0] prod_re [CHANELS];
  logic signed [S_WIDTH-1:0] prod_im [CHANELS];

  // accept a sample, capture its index and advance the ROM address
  always_ff @(posedge clk) begin
    if (rstn) begin
      counter  <= '0;
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_k     <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_x    <= x;
        s1_k    <= counter;
        counter <= (counter == LAST) ? '0 : counter + 1'b1;
      end
    end
  end

  // products formed at S_WIDTH: sign-extended operands give the exact product
  // when S_WIDTH covers it, and the correctly truncated low bits otherwise
  always_comb begin
    for (int unsigned c = 0; c < CHANELS; c++) begin
      prod_re[c] = S_WIDTH'($signed(s1_x[c])) * S_WIDTH'(w_re);
      prod_im[c] = S_WIDTH'($signed(s1_x[c])) * S_WIDTH'(w_im);
    end
  end

  // register the products once the ROM word for stage-1 index is present
  always_ff @(posedge clk) begin
    if (rstn) begin
      s2_valid <= 1'b0;
      s2_k     <= '0;
      for (int unsigned c = 0; c < CHANELS; c++) begin
        p2_re[c] <= '0;
        p2_im[c] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_k <= s1_k;
        for (int unsigned c = 0; c < CHANELS; c++) begin
          p2_re[c] <= prod_re[c];
          p2_im[c] <= prod_im[c];
        end
      end
    end
  end

  // accumulate (restart at k=0), pulse valid_o and finish on the last index
  always_ff @(posedge clk) begin
    if (rstn) begin
      re      <= '0;
      im      <= '0;
      valid_o <= 1'b0;
      finish  <= 1'b0;
    end else begin
      valid_o <= s2_valid;
      finish  <= s2_valid && (s2_k == LAST);
      if (s2_valid) begin
        for (int unsigned c = 0; c < CHANELS; c++) begin
          if (s2_k == '0) begin
            re[c] <= p2_re[c];
            im[c] <= p2_im[c];
          end else begin
            re[c] <= re[c] + p2_re[c];
            im[c] <= im[c] + p2_im[c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_fft_coral.sv
// Self-checking bench for serial_fft_coral: registered-read twiddle ROM model,
// scoreboard queue of expected running sums, table-driven frame plus corner cases.
module tb_serial_fft_coral;

  localparam int N = 4;

  typedef struct {
    logic signed [31:0] re0, im0, re1, im1;
    logic               fin;
  } exp_t;

  typedef struct {
    logic signed [15:0] x0, x1;
    logic signed [31:0] re0, im0, re1, im1;
    logic               fin;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [1:0]              counter;
  logic signed [15:0]      w_re, w_im;
  logic                    valid_i;
  logic signed [1:0][15:0] x;
  logic signed [1:0][31:0] re, im;
  logic                    valid_o, finish;

  logic [3:0]              counter2;
  logic                    valid_i2;
  logic signed [1:0][15:0] x2;
  logic signed [1:0][31:0] re2, im2;
  logic                    valid_o2, finish2;

  logic signed [15:0] rom_re [N];
  logic signed [15:0] rom_im [N];

  exp_t q[$];
  int   vo_cyc_q[$];
  int   fin_cyc_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cnt2 = 0;
  int   fin2_cnt = 0;

  int                 m_k;
  logic signed [31:0] m_re0, m_im0, m_re1, m_im1;
  int                 first_acc;

  serial_fft_coral #(.W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(N), .CHANELS(2)) dut (
    .clk(clk), .rstn(rstn), .counter(counter), .w_re(w_re), .w_im(w_im),
    .valid_i(valid_i), .x(x), .re(re), .im(im), .valid_o(valid_o), .finish(finish)
  );

  serial_fft_coral #(.W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(10), .CHANELS(2)) dut10 (
    .clk(clk), .rstn(rstn), .counter(counter2), .w_re(16'sd1), .w_im(16'sd0),
    .valid_i(valid_i2), .x(x2), .re(re2), .im(im2), .valid_o(valid_o2), .finish(finish2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // registered-read twiddle ROM addressed by the DUT counter
  always @(posedge clk) begin
    w_re <= rom_re[counter];
    w_im <= rom_im[counter];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // output monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rstn === 1'b0) begin
      if (valid_o) begin
        vo_cyc_q.push_back(cyc);
        if (finish) fin_cyc_q.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexpected_valid_o", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("re0", $signed(re[0]), e.re0);
          chk("im0", $signed(im[0]), e.im0);
          chk("re1", $signed(re[1]), e.re1);
          chk("im1", $signed(im[1]), e.im1);
          chk("finish", finish, e.fin);
        end
      end else if (finish) begin
        chk("finish_without_valid", 1, 0);
      end
      if (valid_o2) begin
        cnt2++;
        if (finish2) begin
          fin2_cnt++;
          chk("n10_finish_index", cnt2, 10);
          chk("n10_final_re", $signed(re2[0]), 10);
        end
      end
    end
  end

  // drive one cycle; when accepted, advance the reference model
  task automatic send(input logic v, input logic signed [15:0] a,
                      input logic signed [15:0] b, input logic use_model);
    longint pr0, pi0, pr1, pi1;
    exp_t   e;
    valid_i = v;
    x[0] = a;
    x[1] = b;
    if (v) begin
      pr0 = longint'(a) * longint'(rom_re[m_k]);
      pi0 = longint'(a) * longint'(rom_im[m_k]);
      pr1 = longint'(b) * longint'(rom_re[m_k]);
      pi1 = longint'(b) * longint'(rom_im[m_k]);
      if (m_k == 0) begin
        m_re0 = 32'(pr0); m_im0 = 32'(pi0); m_re1 = 32'(pr1); m_im1 = 32'(pi1);
      end else begin
        m_re0 = m_re0 + 32'(pr0); m_im0 = m_im0 + 32'(pi0);
        m_re1 = m_re1 + 32'(pr1); m_im1 = m_im1 + 32'(pi1);
      end
      e.re0 = m_re0; e.im0 = m_im0; e.re1 = m_re1; e.im1 = m_im1;
      e.fin = (m_k == N - 1);
      if (use_model) q.push_back(e);
      if (first_acc < 0) first_acc = cyc + 1;
      m_k = (m_k == N - 1) ? 0 : m_k + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_queue_empty"}, q.size(), 0);
  endtask

  task automatic clear_marks();
    vo_cyc_q.delete();
    fin_cyc_q.delete();
    first_acc = -1;
  endtask

  task automatic frame_1357(input logic use_model);
    send(1'b1, 16'sd1, 16'sd2, use_model);
    send(1'b1, 16'sd3, 16'sd4, use_model);
    send(1'b1, 16'sd5, 16'sd6, use_model);
    send(1'b1, 16'sd7, 16'sd8, use_model);
  endtask

  task automatic check_final(input string name, input longint r0, input longint i0,
                             input longint r1, input longint i1);
    chk({name, "_re0"}, $signed(re[0]), r0);
    chk({name, "_im0"}, $signed(im[0]), i0);
    chk({name, "_re1"}, $signed(re[1]), r1);
    chk({name, "_im1"}, $signed(im[1]), i1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{x0: 1, x1: 2, re0: 32767,   im0: 0,      re1: 65534,   im1: 0,       fin: 1'b0};
    tbl[1] = '{x0: 3, x1: 4, re0: 32767,   im0: -98301, re1: 65534,   im1: -131068, fin: 1'b0};
    tbl[2] = '{x0: 5, x1: 6, re0: -131068, im0: -98301, re1: -131068, im1: -131068, fin: 1'b0};
    tbl[3] = '{x0: 7, x1: 8, re0: -131068, im0: 131068, re1: -131068, im1: 131068,  fin: 1'b1};

    rom_re = '{16'sd32767, 16'sd0, -16'sd32767, 16'sd0};
    rom_im = '{16'sd0, -16'sd32767, 16'sd0, 16'sd32767};
    rstn = 1'b1; valid_i = 1'b1; x = '1; valid_i2 = 1'b1; x2[0] = 16'sd1; x2[1] = 16'sd1;
    m_k = 0; first_acc = -1;
    m_re0 = '0; m_im0 = '0; m_re1 = '0; m_im1 = '0;

    // reset state, with valid_i asserted to show it is ignored
    repeat (3) @(posedge clk);
    #1;
    chk("rst_counter", counter, 0);
    chk("rst_re0", $signed(re[0]), 0);
    chk("rst_im1", $signed(im[1]), 0);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_finish", finish, 0);
    chk("rst_counter2", counter2, 0);
    valid_i = 1'b0; valid_i2 = 1'b0; x = '0;
    rstn = 1'b0;
    @(posedge clk);
    #1;

    // table-driven frame, consecutive cycles
    clear_marks();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.re0 = tbl[i].re0; e.im0 = tbl[i].im0; e.re1 = tbl[i].re1; e.im1 = tbl[i].im1;
      e.fin = tbl[i].fin;
      q.push_back(e);
      send(1'b1, tbl[i].x0, tbl[i].x1, 1'b0);
    end
    drain("frame");
    chk("frame_vo_count", vo_cyc_q.size(), 4);
    for (int i = 0; i < 4 && i < vo_cyc_q.size(); i++)
      chk("frame_vo_cycle", vo_cyc_q[i], first_acc + 2 + i);
    chk("frame_fin_count", fin_cyc_q.size(), 1);
    if (fin_cyc_q.size() > 0) chk("frame_fin_cycle", fin_cyc_q[0], first_acc + 5);

    // gapped input: two idle cycles between samples, counter holds
    clear_marks();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'(2 * i + 1), 16'(2 * i + 2), 1'b1);
      for (int g = 0; g < 2; g++) begin
        send(1'b0, 16'sh7fff, -16'sd1, 1'b1);
        chk("gap_counter_hold", counter, m_k);
      end
    end
    drain("gap");
    check_final("gap_final", -131068, 131068, -131068, 131068);
    chk("gap_vo_count", vo_cyc_q.size(), 4);
    for (int i = 1; i < vo_cyc_q.size(); i++)
      chk("gap_vo_spacing", vo_cyc_q[i] - vo_cyc_q[i-1], 3);
    chk("gap_fin_count", fin_cyc_q.size(), 1);
    if (fin_cyc_q.size() > 0 && vo_cyc_q.size() > 0)
      chk("gap_fin_on_last", fin_cyc_q[0], vo_cyc_q[vo_cyc_q.size()-1]);

    // back-to-back frames, second frame all ones
    clear_marks();
    frame_1357(1'b1);
    for (int i = 0; i < 4; i++) send(1'b1, 16'sd1, 16'sd1, 1'b1);
    drain("b2b");
    check_final("b2b_final", 0, 0, 0, 0);
    chk("b2b_fin_count", fin_cyc_q.size(), 2);
    if (fin_cyc_q.size() == 2) chk("b2b_fin_spacing", fin_cyc_q[1] - fin_cyc_q[0], 4);

    // reset mid-frame after two accepted samples
    clear_marks();
    send(1'b1, 16'sd9, 16'sd9, 1'b1);
    send(1'b1, 16'sd9, 16'sd9, 1'b1);
    rstn = 1'b1; valid_i = 1'b1; x = '1;
    q.delete();
    m_k = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_counter", counter, 0);
      chk("midrst_re0", $signed(re[0]), 0);
      chk("midrst_im0", $signed(im[0]), 0);
      chk("midrst_valid_o", valid_o, 0);
    end
    rstn = 1'b0; valid_i = 1'b0;
    @(posedge clk);
    #1;
    frame_1357(1'b1);
    drain("midrst");
    check_final("midrst_final", -131068, 131068, -131068, 131068);
    chk("midrst_fin_count", fin_cyc_q.size(), 1);
    chk("midrst_vo_count", vo_cyc_q.size(), 4);

    // overflow: 2^30 products wrapping modulo 2^32
    clear_marks();
    for (int i = 0; i < N; i++) begin
      rom_re[i] = -16'sd32768;
      rom_im[i] = -16'sd32768;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(1'b1, -16'sd32768, -16'sd32768, 1'b1);
    drain("ovf");
    check_final("ovf_final", 0, 0, 0, 0);

    // FRAME_LENGTH=10 instance: counter wraps 9 -> 0, finish on k=9
    valid_i2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 8) chk("n10_counter_at_9", counter2, 9);
      if (i == 9) chk("n10_counter_wrap", counter2, 0);
    end
    valid_i2 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("n10_fin_count", fin2_cnt, 1);
    chk("n10_vo_count", cnt2, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
